// File: rtl/pipe_hazard_scoreboard.sv
// pipe_hazard_scoreboard: in-flight writer tracker resolving forwarding sources and load-use stalls
module pipe_hazard_scoreboard #(
  parameter int NSRC = 2,
  parameter int DEPTH = 3,
  parameter int AW = 5,
  parameter int LOAD_READY_STAGE = 1,
  parameter int SW = $clog2(DEPTH+1),
  parameter logic [31:0] STALL_INIT = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              issue_valid,
  input  logic              issue_reg_write,
  input  logic              issue_is_load,
  input  logic [AW-1:0]     issue_rd,
  input  logic [NSRC-1:0]   src_used,
  input  logic [NSRC*AW-1:0] src_addr,
  input  logic [DEPTH-1:0]  flush_mask,
  output logic              stall,
  output logic [NSRC*SW-1:0] fwd_sel,
  output logic [SW-1:0]     inflight,
  output logic [31:0]       stall_cycles
);
  logic [DEPTH-1:0] vld_q, ld_q, vld_d, ld_d;
  logic [AW-1:0] rd_q [DEPTH];
  logic [AW-1:0] rd_d [DEPTH];
  logic [NSRC-1:0] blk;
  logic ins;
  logic [SW-1:0] cnt;
  // per source, scan oldest to youngest so the youngest match is the one that sticks
  always_comb begin
    fwd_sel = '0;
    blk = '0;
    for (int k = 0; k < NSRC; k++)
      for (int i = DEPTH-1; i >= 0; i--)
        if (src_used[k] && src_addr[k*AW +: AW] != '0 && vld_q[i] && rd_q[i] == src_addr[k*AW +: AW]) begin
          fwd_sel[k*SW +: SW] = SW'(i+1);
          blk[k] = ld_q[i] && i < LOAD_READY_STAGE;
        end
    stall = |blk;
  end
  // next entry state: shift with insert, or freeze in place under hold; flush applies either way
  always_comb begin
    ins = issue_valid & ~stall & issue_reg_write & (issue_rd != '0) & ~flush_mask[0];
    vld_d = (hold ? vld_q : DEPTH'({vld_q, ins})) & ~flush_mask;
    ld_d = hold ? ld_q : DEPTH'({ld_q, issue_is_load});
    rd_d[0] = hold ? rd_q[0] : issue_rd;
    for (int i = 1; i < DEPTH; i++) rd_d[i] = hold ? rd_q[i] : rd_q[i-1];
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + SW'(vld_d[i]);
  end
  // state registers, in-flight count and saturating stall counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      ld_q <= '0;
      for (int i = 0; i < DEPTH; i++) rd_q[i] <= '0;
      inflight <= '0;
      stall_cycles <= STALL_INIT;
    end else begin
      vld_q <= vld_d;
      ld_q <= ld_d;
      for (int i = 0; i < DEPTH; i++) rd_q[i] <= rd_d[i];
      inflight <= cnt;
      stall_cycles <= (stall && !hold && !(&stall_cycles)) ? stall_cycles + 32'd1 : stall_cycles;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// tb_pipe_hazard_scoreboard: directed stimulus with queued expectations checked by a monitor
module tb_pipe_hazard_scoreboard;
  logic clk = 0;
  logic reset = 0;
  logic hold = 0, issue_valid = 0, issue_reg_write = 0, issue_is_load = 0;
  logic [4:0] issue_rd = 0;
  logic [1:0] src_used = 0;
  logic [9:0] src_addr = 0;
  logic [2:0] flush_mask = 0;
  logic stall, sat_stall;
  logic [3:0] fwd_sel, sat_fwd;
  logic [1:0] inflight, sat_inflight;
  logic [31:0] stall_cycles, sat_cycles;
  int total = 0, passed = 0;

  typedef struct {
    string nm;
    logic st;
    logic [1:0] f0, f1, inf;
    logic [31:0] sc;
    bit cs;
    logic [31:0] sat;
  } exp_t;
  exp_t q[$];

  pipe_hazard_scoreboard dut (
    .clk(clk), .reset(reset), .hold(hold), .issue_valid(issue_valid),
    .issue_reg_write(issue_reg_write), .issue_is_load(issue_is_load), .issue_rd(issue_rd),
    .src_used(src_used), .src_addr(src_addr), .flush_mask(flush_mask),
    .stall(stall), .fwd_sel(fwd_sel), .inflight(inflight), .stall_cycles(stall_cycles)
  );

  pipe_hazard_scoreboard #(.STALL_INIT(32'hFFFF_FFFC)) sat_dut (
    .clk(clk), .reset(reset), .hold(hold), .issue_valid(issue_valid),
    .issue_reg_write(issue_reg_write), .issue_is_load(issue_is_load), .issue_rd(issue_rd),
    .src_used(src_used), .src_addr(src_addr), .flush_mask(flush_mask),
    .stall(sat_stall), .fwd_sel(sat_fwd), .inflight(sat_inflight), .stall_cycles(sat_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s.%s: act=%0h exp=%0h", nm, fld, act, exp);
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "stall", 32'(stall), 32'(e.st));
      chk(e.nm, "fwd0", 32'(fwd_sel[1:0]), 32'(e.f0));
      chk(e.nm, "fwd1", 32'(fwd_sel[3:2]), 32'(e.f1));
      chk(e.nm, "inflight", 32'(inflight), 32'(e.inf));
      chk(e.nm, "stall_cycles", stall_cycles, e.sc);
      if (e.cs) chk(e.nm, "sat_cycles", sat_cycles, e.sat);
    end
  end

  task automatic cyc(input string nm, input bit h, input bit iv, input bit rw, input bit ld, input int rd,
                     input bit u0, input int a0, input bit u1, input int a1, input int fm,
                     input bit est, input int ef0, input int ef1, input int einf, input int esc,
                     input bit cs = 0, input logic [31:0] es = '0);
    exp_t e;
    hold = h; issue_valid = iv; issue_reg_write = rw; issue_is_load = ld; issue_rd = 5'(rd);
    src_used = {u1, u0}; src_addr = {5'(a1), 5'(a0)}; flush_mask = 3'(fm);
    e.nm = nm; e.st = est; e.f0 = 2'(ef0); e.f1 = 2'(ef1); e.inf = 2'(einf); e.sc = 32'(esc);
    e.cs = cs; e.sat = es;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    @(posedge clk); #1;
    for (int r = 0; r < 3; r++)
      cyc("in_reset", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(31)),
          1'($urandom), int'($urandom_range(31)), 1'($urandom), int'($urandom_range(31)), int'($urandom_range(7)),
          0, 0, 0, 0, 0);
    reset = 1;
    cyc("idle0", 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0);
    cyc("idle1", 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0);
    cyc("alu_issue", 0,1,1,0,8, 0,0,0,0,0, 0,0,0,0,0);
    cyc("alu_fwd_E", 0,0,0,0,0, 1,8,0,0,0, 0,1,0,1,0);
    cyc("alu_fwd_M", 0,0,0,0,0, 1,8,0,0,0, 0,2,0,1,0);
    cyc("alu_fwd_W", 0,0,0,0,0, 1,8,0,0,0, 0,3,0,1,0);
    cyc("alu_retired", 0,0,0,0,0, 1,8,0,0,0, 0,0,0,0,0);
    cyc("lw_issue", 0,1,1,1,9, 0,0,0,0,0, 0,0,0,0,0);
    cyc("load_use_stall", 0,1,1,0,10, 1,9,0,0,0, 1,1,0,1,0);
    cyc("load_use_fwd_M", 0,1,1,0,10, 1,9,0,0,0, 0,2,0,1,1);
    cyc("drain0", 0,0,0,0,0, 0,0,0,0,0, 0,0,0,2,1);
    cyc("drain1", 0,0,0,0,0, 0,0,0,0,0, 0,0,0,1,1);
    cyc("drain2", 0,0,0,0,0, 0,0,0,0,0, 0,0,0,1,1);
    cyc("prio_alu5", 0,1,1,0,5, 0,0,0,0,0, 0,0,0,0,1);
    cyc("prio_ld5", 0,1,1,1,5, 0,0,0,0,0, 0,0,0,1,1);
    cyc("prio_youngest", 0,0,0,0,0, 1,5,1,0,0, 1,1,0,2,1);
    cyc("rd0_no_insert", 0,1,1,0,0, 1,5,1,0,0, 0,2,0,2,2);
    cyc("rd0_inflight", 0,0,0,0,0, 0,0,1,0,0, 0,0,0,1,2);
    cyc("empty", 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,2);
    cyc("fill5", 0,1,1,0,5, 0,0,0,0,0, 0,0,0,0,2);
    cyc("fill4", 0,1,1,0,4, 0,0,0,0,0, 0,0,0,1,2);
    cyc("fill3_ld", 0,1,1,1,3, 0,0,0,0,0, 0,0,0,2,2);
    for (int h = 0; h < 3; h++)
      cyc("hold", 1,1,1,0,7, 1,3,1,5,0, 1,1,3,3,2);
    cyc("flush_M", 0,1,1,0,6, 1,4,1,5,2, 0,2,3,3,2);
    cyc("flush_killed", 0,0,0,0,0, 1,3,1,4,0, 0,0,3,2,2);
    cyc("flush_all", 0,1,1,0,11, 1,6,0,0,7, 0,2,0,1,2);
    cyc("flush_all_empty", 0,0,0,0,0, 1,11,1,6,0, 0,0,0,0,2);
    cyc("ld12", 0,1,1,1,12, 0,0,0,0,0, 0,0,0,0,2);
    cyc("flush_stall", 0,0,0,0,0, 1,12,0,0,7, 1,1,0,1,2);
    cyc("flush_stall_clear", 0,0,0,0,0, 1,12,0,0,0, 0,0,0,0,3, 1, 32'hFFFF_FFFF);
    cyc("alu13", 0,1,1,0,13, 0,0,0,0,0, 0,0,0,0,3);
    cyc("hold_flush", 1,0,0,0,0, 1,13,0,0,1, 0,1,0,1,3);
    cyc("hold_flush_gone", 0,0,0,0,0, 1,13,0,0,0, 0,0,0,0,3);
    cyc("ld14", 0,1,1,1,14, 0,0,0,0,0, 0,0,0,0,3);
    cyc("stall14", 0,0,0,0,0, 1,14,0,0,0, 1,1,0,1,3);
    cyc("ld15", 0,1,1,1,15, 0,0,0,0,0, 0,0,0,1,4);
    cyc("stall15", 0,0,0,0,0, 1,15,1,14,0, 1,1,3,2,4);
    cyc("sat_hold", 0,0,0,0,0, 0,0,0,0,0, 0,0,0,1,5, 1, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    total++;
    if (q.size() == 0) passed++;
    else $display("FAIL queue_drain: act=%0d exp=0", q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_scoreboard.md
Name: pipe_hazard_scoreboard

Overview:
Parametrised hazard and forwarding tracker for the in-order pipeline, replacing the fixed stall/forward struct logic. It holds a shift register of in-flight register writers for DEPTH stages after decode (E, M, W by default). For NSRC source operands in decode it resolves a forwarding source and a load-use stall. It also provides a pipeline flush mask, an external hold, an in-flight count and a stall performance counter.

Parameters:
NSRC, 2, number of decode source operands checked
DEPTH, 3, tracked stages after decode (index 0 = E, 1 = M, 2 = W)
AW, 5, register address width
LOAD_READY_STAGE, 1, first stage index at which load data can be forwarded; must be < DEPTH
SW, $clog2(DEPTH+1), width of each forward-select field and of the in-flight count

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
hold  in  1  external pipeline freeze (memory wait); tracker does not shift
issue_valid  in  1  decode instruction attempts to advance into stage 0
issue_reg_write  in  1  issuing instruction writes a register
issue_is_load  in  1  issuing instruction is a load
issue_rd  in  AW  issuing destination register
src_used  in  NSRC  per-source "operand read" flag
src_addr  in  NSRC*AW  source addresses; source k is at bits [k*AW +: AW]
flush_mask  in  DEPTH  bit i kills the entry entering stage i at this edge
stall  out  1  decode must stall (combinational)
fwd_sel  out  NSRC*SW  per source: 0 = register file, i+1 = forward from stage i
inflight  out  SW  registered count of valid tracked entries
stall_cycles  out  32  saturating count of stall-induced bubbles

Behaviour:
- Entry i fields: valid, rd, is_load.
- Reset (reset low, async):
  - All entries invalid.
  - inflight = 0 and stall_cycles = 0.
  - stall = 0 and fwd_sel = 0, because both are derived only from state.
- Match for source k at stage i requires all of:
  - src_used[k];
  - src_addr_k != 0;
  - entry i valid;
  - entry i rd == src_addr_k.
- The youngest match (lowest i) wins, and fwd_sel_k = i+1. With no match, fwd_sel_k = 0.
- Entry i is ready if !is_load or i >= LOAD_READY_STAGE.
- stall = 1 if any source's youngest match is not ready. An older ready match never overrides a younger unready one.
- Shift at a rising edge with hold = 0:
  - stage[0] loads {issue_valid & !stall & issue_reg_write & issue_rd != 0 & !flush_mask[0], issue_rd, issue_is_load}.
  - stage[i] takes stage[i-1] with valid ANDed with !flush_mask[i].
  - The entry in stage DEPTH-1 retires.
- Rising edge with hold = 1:
  - No shift and no insert.
  - stage[i].valid is cleared where flush_mask[i] = 1, in place.
- stall and hold both high: hold governs, so there is no shift and no bubble.
- flush_mask = all-ones: every entry is invalid after the edge, so stall = 0 in the following cycle.
- inflight is updated each edge to the popcount of the next-state valid bits. It is registered, so it matches the entries after the same edge.
- stall_cycles increments at each edge where stall & !hold, and saturates at 32'hFFFF_FFFF.
- Register 0 is never tracked or matched.
- Reset asserted mid-operation clears everything immediately, asynchronously. Release is sampled at the next clk edge.

Test Plan:
- Reset: hold reset low and drive random inputs -> stall = 0, fwd_sel = 0, inflight = 0, stall_cycles = 0; after release with no issue, all outputs stay 0.
- ALU chain: issue add rd = 8, then next cycle src_addr0 = 8 with src_used0 = 1 -> stall = 0 and fwd_sel0 = 1. One cycle later (entry now in M) -> fwd_sel0 = 2; after two more edges -> 0.
- Load-use: issue lw rd = 9, then a consumer of 9 -> stall = 1 for one cycle and stall_cycles = 1. Next cycle stall = 0 and fwd_sel0 = 2; stage 0 holds a bubble and inflight = 1.
- Youngest priority: stage 1 holds ALU rd = 5 and stage 0 holds load rd = 5, source reads 5 -> stall = 1, not fwd_sel = 2. Also src_addr = 0 with a matching rd = 0 issue -> fwd_sel = 0 and no entry inserted.
- Hold and flush: fill entries rd = 3, 4, 5, then hold = 1 for 3 cycles -> entries unchanged and stall_cycles frozen. Then hold = 0 with flush_mask = 3'b010 -> the rd = 3 entry is killed entering M, and inflight drops by 1.
- Saturation: force stall for 2^32 + 5 cycles (or use a bench-only counter preload) -> stall_cycles = 32'hFFFF_FFFF and does not wrap.
